pipeline_stage1: RTL and testbench

- Decode/assembly stage directly downstream of pipeline_stage0; consumes its instruction_out byte stream.
- Collects an opcode byte plus 0–2 immediate operand bytes into one instruction word and holds it in an output register for the execute stage.
- Generates fetch_suppress back to stage0 when the output register is full and execute is stalled, so stage0 replays the held byte.

---
 rtl/pipeline_stage1.sv | 134 +++++++++++++
 tb/tb_pipeline_stage1.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stage1.sv
// Decode/assembly stage: gathers opcode + 0..2 immediate bytes from stage0 into a held instruction word.
// Optional perf counters enabled with `define PIPELINE_STAGE1_PERF_EN.
module pipeline_stage1 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [WIDTH-1:0]   instruction_in,
   input  logic               bus_request,
   input  logic               stall_in,
   input  logic               flush,
   output logic               fetch_suppress,
   output logic [WIDTH-1:0]   opcode_out,
   output logic [2*WIDTH-1:0] operand_out,
   output logic               instr_valid,
   output logic               busy
`ifdef PIPELINE_STAGE1_PERF_EN
   ,
   output logic [15:0]        perf_instr_count,
   output logic [15:0]        perf_stall_count
`endif
);

   typedef enum logic [1:0] {S_OPCODE, S_IMM_LO, S_IMM_HI} state_t;

   state_t               state_q;
   logic                 valid_q;
   logic [WIDTH-1:0]     opcode_q;
   logic [2*WIDTH-1:0]   operand_q;
   logic [WIDTH-1:0]     pop_q;
   logic [WIDTH-1:0]     plo_q;

   logic                 accept;
   logic                 drain;
   logic                 complete;
   logic [1:0]           len;
   logic [WIDTH-1:0]     opcode_d;
   logic [2*WIDTH-1:0]   operand_d;

   function automatic logic [1:0] op_len(input logic [WIDTH-1:0] op);
      case (op[WIDTH-1 -: 2])
         2'b01:   op_len = 2'd1;
         2'b10:   op_len = 2'd2;
         default: op_len = 2'd0;
      endcase
   endfunction

   assign fetch_suppress = valid_q && stall_in;
   // accept already implies the output register can load (fetch_suppress is low)
   assign accept         = !bus_request && !fetch_suppress && !flush;
   assign drain          = valid_q && !stall_in;
   assign opcode_d       = (state_q == S_OPCODE) ? instruction_in : pop_q;
   assign len            = op_len(opcode_d);

   always_comb begin
      operand_d = '0;
      complete  = 1'b0;
      case (state_q)
         S_OPCODE: complete = accept && (len == 2'd0);
         S_IMM_LO: begin
            operand_d = {{WIDTH{1'b0}}, instruction_in};
            complete  = accept && (len == 2'd1);
         end
         S_IMM_HI: begin
            operand_d = {instruction_in, plo_q};
            complete  = accept;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_OPCODE;
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         operand_q <= '0;
         pop_q     <= '0;
         plo_q     <= '0;
      end else if (flush) begin
         state_q <= S_OPCODE;
         valid_q <= 1'b0;
         pop_q   <= '0;
         plo_q   <= '0;
      end else begin
         if (drain) valid_q <= 1'b0;
         if (accept) begin
            case (state_q)
               S_OPCODE: if (len != 2'd0) begin
                  pop_q   <= instruction_in;
                  plo_q   <= '0;
                  state_q <= S_IMM_LO;
               end
               S_IMM_LO: begin
                  plo_q   <= instruction_in;
                  state_q <= S_IMM_HI;
               end
               default: state_q <= S_OPCODE;
            endcase
            if (complete) begin
               state_q   <= S_OPCODE;
               valid_q   <= 1'b1;
               opcode_q  <= opcode_d;
               operand_q <= operand_d;
            end
         end
      end
   end

   assign opcode_out  = opcode_q;
   assign operand_out = operand_q;
   assign instr_valid = valid_q;
   assign busy        = (state_q != S_OPCODE);

`ifdef PIPELINE_STAGE1_PERF_EN
   logic [15:0] instr_cnt_q;
   logic [15:0] stall_cnt_q;

   // saturating; flush deliberately does not clear these
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (complete && instr_cnt_q != 16'hFFFF) instr_cnt_q <= instr_cnt_q + 16'd1;
         if (fetch_suppress && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign perf_instr_count = instr_cnt_q;
   assign perf_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stage1.sv
// Table-driven bench for pipeline_stage1 with an expected-result queue per driven cycle.
module tb_pipeline_stage1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  instruction_in;
   logic        bus_request, stall_in, flush;
   logic        fetch_suppress, instr_valid, busy;
   logic [7:0]  opcode_out;
   logic [15:0] operand_out;
`ifdef PIPELINE_STAGE1_PERF_EN
   logic [15:0] perf_instr_count, perf_stall_count;
`endif

   int checks = 0;
   int errors = 0;

   pipeline_stage1 #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .instruction_in(instruction_in),
      .bus_request(bus_request), .stall_in(stall_in), .flush(flush),
      .fetch_suppress(fetch_suppress), .opcode_out(opcode_out),
      .operand_out(operand_out), .instr_valid(instr_valid), .busy(busy)
`ifdef PIPELINE_STAGE1_PERF_EN
      , .perf_instr_count(perf_instr_count), .perf_stall_count(perf_stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic br, st, fl;
      logic [7:0] din;
      logic fs, vld;
      logic [7:0] op;
      logic [15:0] opr;
      logic busy;
   } vec_t;

   typedef struct {
      logic vld;
      logic [7:0] op;
      logic [15:0] opr;
      logic busy;
   } exp_t;

   vec_t tbl[21];
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic br, logic st, logic fl, logic [7:0] din, logic fs,
                               logic vld, logic [7:0] op, logic [15:0] opr, logic bsy);
      vec_t v;
      v.br = br; v.st = st; v.fl = fl; v.din = din; v.fs = fs;
      v.vld = vld; v.op = op; v.opr = opr; v.busy = bsy;
      return v;
   endfunction

   task automatic check_outputs(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, " scoreboard empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, " instr_valid"}, instr_valid, e.vld);
         chk({tag, " opcode_out"}, opcode_out, e.op);
         chk({tag, " operand_out"}, operand_out, e.opr);
         chk({tag, " busy"}, busy, e.busy);
      end
   endtask

   task automatic drive(input logic br, input logic st, input logic fl, input logic [7:0] din,
                        input logic fs, input logic vld, input logic [7:0] op,
                        input logic [15:0] opr, input logic bsy, input string tag);
      exp_t e;
      @(negedge clk);
      bus_request = br; stall_in = st; flush = fl; instruction_in = din;
      e.vld = vld; e.op = op; e.opr = opr; e.busy = bsy;
      sb.push_back(e);
      #1 chk({tag, " fetch_suppress"}, fetch_suppress, fs);
      @(posedge clk);
      #1 check_outputs(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = mk(0,0,0,8'h80, 0, 0,8'h00,16'h0000,1);
      tbl[1]  = mk(0,0,0,8'h34, 0, 0,8'h00,16'h0000,1);
      tbl[2]  = mk(0,0,0,8'h12, 0, 1,8'h80,16'h1234,0);
      tbl[3]  = mk(0,0,0,8'h41, 0, 0,8'h80,16'h1234,1);
      tbl[4]  = mk(1,0,0,8'hFF, 0, 0,8'h80,16'h1234,1);
      tbl[5]  = mk(1,0,0,8'hFF, 0, 0,8'h80,16'h1234,1);
      tbl[6]  = mk(0,0,0,8'hAB, 0, 1,8'h41,16'h00AB,0);
      tbl[7]  = mk(0,1,0,8'h07, 1, 1,8'h41,16'h00AB,0);
      tbl[8]  = mk(0,0,0,8'h07, 0, 1,8'h07,16'h0000,0);
      tbl[9]  = mk(0,0,0,8'h01, 0, 1,8'h01,16'h0000,0);
      tbl[10] = mk(0,0,0,8'h02, 0, 1,8'h02,16'h0000,0);
      tbl[11] = mk(0,0,0,8'h03, 0, 1,8'h03,16'h0000,0);
      tbl[12] = mk(0,0,0,8'hC5, 0, 1,8'hC5,16'h0000,0);
      tbl[13] = mk(0,1,0,8'h80, 1, 1,8'hC5,16'h0000,0);
      tbl[14] = mk(1,1,0,8'h80, 1, 1,8'hC5,16'h0000,0);
      tbl[15] = mk(0,0,0,8'h80, 0, 0,8'hC5,16'h0000,1);
      tbl[16] = mk(0,0,0,8'h11, 0, 0,8'hC5,16'h0000,1);
      tbl[17] = mk(0,0,1,8'h22, 0, 0,8'hC5,16'h0000,0);
      tbl[18] = mk(0,0,0,8'h22, 0, 1,8'h22,16'h0000,0);
      tbl[19] = mk(0,1,1,8'h05, 1, 0,8'h22,16'h0000,0);
      tbl[20] = mk(0,0,0,8'h05, 0, 1,8'h05,16'h0000,0);

      reset_n = 1'b0; bus_request = 1'b0; stall_in = 1'b0; flush = 1'b0; instruction_in = 8'h00;
      #2;
      chk("reset instr_valid", instr_valid, 0);
      chk("reset opcode_out", opcode_out, 0);
      chk("reset operand_out", operand_out, 0);
      chk("reset busy", busy, 0);
      chk("reset fetch_suppress", fetch_suppress, 0);
      @(negedge clk); reset_n = 1'b1;

      for (int i = 0; i < 21; i++)
         drive(tbl[i].br, tbl[i].st, tbl[i].fl, tbl[i].din, tbl[i].fs,
               tbl[i].vld, tbl[i].op, tbl[i].opr, tbl[i].busy, $sformatf("vec%0d", i));

`ifdef PIPELINE_STAGE1_PERF_EN
      chk("perf_instr_count", perf_instr_count, 16'd9);
      chk("perf_stall_count", perf_stall_count, 16'd4);
`endif

      // asynchronous reset while waiting for the high immediate byte
      drive(0,0,0,8'h80, 0, 0,8'h05,16'h0000,1, "rst_a");
      drive(0,0,0,8'h34, 0, 0,8'h05,16'h0000,1, "rst_b");
      @(negedge clk);
      reset_n = 1'b0; instruction_in = 8'h05;
      #1;
      chk("midrst instr_valid", instr_valid, 0);
      chk("midrst opcode_out", opcode_out, 0);
      chk("midrst operand_out", operand_out, 0);
      chk("midrst busy", busy, 0);
`ifdef PIPELINE_STAGE1_PERF_EN
      chk("midrst perf_instr_count", perf_instr_count, 0);
`endif
      @(negedge clk); reset_n = 1'b1;
      drive(0,0,0,8'h05, 0, 1,8'h05,16'h0000,0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
